// File: rtl/pow_frame_acc_if.sv
// Handshake bundle between the pow8 sample stream (64-bit in) and the 32-bit bus side.
// The slave modport is the accumulator's view; master is the view of whatever drives it.
interface pow_frame_acc_if;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_sat;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_sat
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last, m_sat
    );
endinterface

// File: rtl/pow_frame_acc.sv
// Sums FRAME_LEN unsigned 64-bit samples into a saturating total and emits it as
// two 32-bit beats (low word, then high word with m_last). Input is stalled while sending.
module pow_frame_acc #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rstn,
    pow_frame_acc_if.slave bus
);

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       acc_q, acc_d;
    logic              sat_q, sat_d;
    logic              s_hs;
    logic [64:0]       sum;

    assign s_hs = bus.s_valid && (state_q == ACC);
    assign sum  = {1'b0, acc_q} + {1'b0, bus.s_data};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (s_hs && (cnt_q == LAST_CNT)) state_d = SEND_LO;
            SEND_LO: if (bus.m_ready) state_d = SEND_HI;
            SEND_HI: if (bus.m_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // The first sample of a frame overwrites the total, which also clears sat.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        sat_d = sat_q;
        if (s_hs) begin
            if (cnt_q == '0) begin
                acc_d = bus.s_data;
                sat_d = 1'b0;
            end else begin
                acc_d = sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
                sat_d = sat_q | sum[64];
            end
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.s_ready = (state_q == ACC);
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        bus.m_sat   = 1'b0;
        case (state_q)
            SEND_LO: begin
                bus.m_valid = 1'b1;
                bus.m_data  = acc_q[31:0];
                bus.m_sat   = sat_q;
            end
            SEND_HI: begin
                bus.m_valid = 1'b1;
                bus.m_data  = acc_q[63:32];
                bus.m_last  = 1'b1;
                bus.m_sat   = sat_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pow_frame_acc.sv
// Bench for pow_frame_acc: three instances (FRAME_LEN 4, 2, 1) share stimulus; one is
// selected at a time, expected beats go to a queue and are popped by a negedge monitor.
module tb_pow_frame_acc;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        sat;
    } beat_t;

    typedef struct packed {
        logic [1:0]       dut;
        logic [2:0]       n;
        logic             gap;
        logic [3:0][63:0] smp;
        logic [31:0]      lo;
        logic [31:0]      hi;
        logic             sat;
    } vec_t;

    localparam int NVEC = 12;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic [63:0] s_data;
    logic        m_ready;

    logic        sel_s_ready, sel_m_valid, sel_m_last, sel_m_sat;
    logic [31:0] sel_m_data;
    logic [1:0]  sel;

    int    checks = 0;
    int    failures = 0;
    int    mv_cycles = 0;
    beat_t exp_q[$];
    vec_t  vecs[NVEC];

    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last, hold_sat;

    pow_frame_acc_if if4();
    pow_frame_acc_if if2();
    pow_frame_acc_if if1();

    assign if4.s_valid = s_valid;
    assign if4.s_data  = s_data;
    assign if4.m_ready = m_ready;
    assign if2.s_valid = s_valid;
    assign if2.s_data  = s_data;
    assign if2.m_ready = m_ready;
    assign if1.s_valid = s_valid;
    assign if1.s_data  = s_data;
    assign if1.m_ready = m_ready;

    pow_frame_acc #(.FRAME_LEN(4), .CNT_W(16)) u_dut4 (.clk(clk), .rstn(rstn), .bus(if4));
    pow_frame_acc #(.FRAME_LEN(2), .CNT_W(16)) u_dut2 (.clk(clk), .rstn(rstn), .bus(if2));
    pow_frame_acc #(.FRAME_LEN(1), .CNT_W(16)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd1: begin
                sel_s_ready = if2.s_ready; sel_m_valid = if2.m_valid; sel_m_data = if2.m_data;
                sel_m_last  = if2.m_last;  sel_m_sat   = if2.m_sat;
            end
            2'd2: begin
                sel_s_ready = if1.s_ready; sel_m_valid = if1.m_valid; sel_m_data = if1.m_data;
                sel_m_last  = if1.m_last;  sel_m_sat   = if1.m_sat;
            end
            default: begin
                sel_s_ready = if4.s_ready; sel_m_valid = if4.m_valid; sel_m_data = if4.m_data;
                sel_m_last  = if4.m_last;  sel_m_sat   = if4.m_sat;
            end
        endcase
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] dut, input logic [2:0] n, input logic gap,
                                input logic [63:0] s0, input logic [63:0] s1,
                                input logic [63:0] s2, input logic [63:0] s3,
                                input logic [31:0] lo, input logic [31:0] hi, input logic sat);
        vec_t v;
        v.dut = dut; v.n = n; v.gap = gap;
        v.smp[0] = s0; v.smp[1] = s1; v.smp[2] = s2; v.smp[3] = s3;
        v.lo = lo; v.hi = hi; v.sat = sat;
        return v;
    endfunction

    task automatic push_frame(input logic [31:0] lo, input logic [31:0] hi, input logic sat);
        exp_q.push_back('{data: lo, last: 1'b0, sat: sat});
        exp_q.push_back('{data: hi, last: 1'b1, sat: sat});
    endtask

    // All input changes happen 1 time unit after a rising edge.
    task automatic apply_stimulus(input logic [63:0] d);
        logic accepted;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sel_s_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check_output("sample_accepted", accepted, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_output("drain_queue_empty", exp_q.size(), 0);
        check_output("s_ready_after_hi", sel_s_ready, 1);
        check_output("m_valid_after_hi", sel_m_valid, 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rstn    = 1'b0;
        #2;
        check_output("rst_s_ready", sel_s_ready, 1);
        check_output("rst_m_valid", sel_m_valid, 0);
        check_output("rst_m_data",  sel_m_data, 0);
        check_output("rst_m_last",  sel_m_last, 0);
        check_output("rst_m_sat",   sel_m_sat, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Scoreboard pop, idle-output and back-pressure stability checks.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_valid = 1'b0;
        end else begin
            if (sel_m_valid) mv_cycles++;
            else check_output("m_sat_idle", sel_m_sat, 0);
            if (hold_valid) begin
                check_output("hold_m_valid", sel_m_valid, 1);
                check_output("hold_m_data",  sel_m_data, hold_data);
                check_output("hold_m_last",  sel_m_last, hold_last);
                check_output("hold_m_sat",   sel_m_sat, hold_sat);
                check_output("hold_s_ready", sel_s_ready, 0);
            end
            if (sel_m_valid && m_ready) begin
                check_output("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_output("beat_m_data", sel_m_data, b.data);
                    check_output("beat_m_last", sel_m_last, b.last);
                    check_output("beat_m_sat",  sel_m_sat, b.sat);
                end
            end
            hold_valid = sel_m_valid && !m_ready;
            hold_data  = sel_m_data;
            hold_last  = sel_m_last;
            hold_sat   = sel_m_sat;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] prev_dut;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; sel = 2'd0;

        vecs[0]  = mk(0, 4, 0, 64'd1, 64'd256, 64'd6561, 64'd65536, 32'h0001_1AA2, 32'h0, 0);
        vecs[1]  = mk(0, 4, 1, 64'd10, 64'd20, 64'd30, 64'd40, 32'h64, 32'h0, 0);
        vecs[2]  = mk(0, 4, 0, 64'h1_0000_0000, 64'h2_0000_0003, 64'd5, 64'd0, 32'h8, 32'h3, 0);
        vecs[3]  = mk(0, 4, 0, ALL_ONES, 64'd1, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        vecs[4]  = mk(0, 4, 0, 64'd1, 64'd1, 64'd1, 64'd1, 32'h4, 32'h0, 0);
        vecs[5]  = mk(1, 2, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        vecs[6]  = mk(1, 2, 0, 64'd1, 64'd2, 64'd0, 64'd0, 32'h3, 32'h0, 0);
        vecs[7]  = mk(1, 2, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        vecs[8]  = mk(1, 2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        vecs[9]  = mk(2, 1, 0, 64'd7, 64'd0, 64'd0, 64'd0, 32'h7, 32'h0, 0);
        vecs[10] = mk(2, 1, 0, 64'd9, 64'd0, 64'd0, 64'd0, 32'h9, 32'h0, 0);
        vecs[11] = mk(2, 1, 0, ALL_ONES, 64'd0, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        prev_dut = 2'd3;
        for (int r = 0; r < NVEC; r++) begin
            if (vecs[r].dut != prev_dut) begin
                sel = vecs[r].dut;
                do_reset();
                prev_dut = vecs[r].dut;
            end
            m_ready   = 1'b1;
            mv_cycles = 0;
            push_frame(vecs[r].lo, vecs[r].hi, vecs[r].sat);
            for (int k = 0; k < int'(vecs[r].n); k++) begin
                if (vecs[r].gap && k > 0) begin
                    @(posedge clk);
                    #1;
                end
                apply_stimulus(vecs[r].smp[k]);
            end
            check_output($sformatf("v%0d_m_valid_latency", r), sel_m_valid, 1);
            check_output($sformatf("v%0d_s_ready_low", r), sel_s_ready, 0);
            drain();
            check_output($sformatf("v%0d_m_valid_cycles", r), mv_cycles, 2);
        end

        // Back-pressure: the beat must hold and the offered sample 99 must not be taken.
        sel = 2'd0;
        do_reset();
        m_ready = 1'b0;
        push_frame(32'h1A, 32'h0, 1'b0);
        apply_stimulus(64'd5); apply_stimulus(64'd6); apply_stimulus(64'd7); apply_stimulus(64'd8);
        s_valid = 1'b1;
        s_data  = 64'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("bp_s_ready", sel_s_ready, 0);
            check_output("bp_m_valid", sel_m_valid, 1);
        end
        s_valid = 1'b0;
        drain();
        push_frame(32'h8, 32'h0, 1'b0);
        apply_stimulus(64'd2); apply_stimulus(64'd2); apply_stimulus(64'd2); apply_stimulus(64'd2);
        drain();

        // Reset mid-frame discards the partial total.
        apply_stimulus(64'd5); apply_stimulus(64'd5);
        do_reset();
        push_frame(32'h4, 32'h0, 1'b0);
        apply_stimulus(64'd1); apply_stimulus(64'd1); apply_stimulus(64'd1); apply_stimulus(64'd1);
        drain();

        // Reset mid-send drops the pending beats entirely.
        m_ready = 1'b0;
        apply_stimulus(64'd3); apply_stimulus(64'd3); apply_stimulus(64'd3); apply_stimulus(64'd3);
        @(posedge clk);
        #1;
        check_output("pre_rst_m_valid", sel_m_valid, 1);
        do_reset();
        m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_output("post_rst_m_valid", sel_m_valid, 0);
        push_frame(32'h6, 32'h0, 1'b0);
        apply_stimulus(64'd2); apply_stimulus(64'd2); apply_stimulus(64'd1); apply_stimulus(64'd1);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
